interrupt_acknowledge_sequencer: RTL and testbench
==================================================

// Module: interrupt_acknowledge_sequencer
// PURPOSE
//  Control and priority block that sequences the 8-bit interrupt request register of the 8259 PIC.
//  Masks pending requests and resolves priority against the in-service register (fully nested).
//  Raises INT, runs the two-pulse INTA handshake and drives freeze/clear into the IRR.
//  Owns the ISR, the EOI/AEOI handling and the 8-bit vector sent to the data bus.
// PARAMETERS
//  ACK_TIMEOUT  255  max clock cycles allowed in WAIT2 before the sequence aborts (>=2)
// PORTS
//  clock                       in   1  single system clock; all state changes on its rising edge
//  reset_n                     in   1  asynchronous, active-low reset
//  icw1_reset                  in   1  synchronous re-init pulse (ICW1 write); same effect as reset_n
//  interrupt_request_register  in   8  IRR contents
//  interrupt_mask              in   8  IMR; 1 = masked
//  vector_base                 in   5  T7..T3 from ICW2
//  auto_eoi                    in   1  1 = clear ISR bit at end of second INTA
//  priority_rotate             in   1  1 = EOIs rotate priority (cleared level becomes lowest)
//  eoi_nonspecific             in   1  pulse: clear highest-priority set ISR bit
//  eoi_specific                in   1  pulse: clear ISR[eoi_level]
//  eoi_level                   in   3  level for specific EOI
//  inta_n                      in   1  INTA pin, synchronous to clock, active low
//  interrupt                   out  1  INT pin to CPU
//  freeze                      out  1  hold IRR during acknowledge
//  clear_interrupt_request     out  8  one-hot one-cycle clear into IRR
//  in_service_register         out  8  ISR
//  vector_out                  out  8  {vector_base, level}
//  vector_valid                out  1  drive data bus with vector_out
//  ack_error                   out  1  one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (reset_n low or icw1_reset): state IDLE; ISR=0; lowest_prio=7 (IR0 highest).
//   All outputs are 0, vector_out=0, and inta_n_q=1.
//  Priority order: IR(lowest_prio+1) highest, wrapping mod 8, down to IR(lowest_prio) lowest.
//  eligible = IRR & ~IMR; best = highest-priority eligible bit.
//  interrupt = (state==IDLE) & best exists & best outranks the highest set ISR bit. Combinational.
//  INTA falling edge = inta_n_q & ~inta_n, where inta_n_q is inta_n registered.
//  FSM:
//   IDLE : on INTA falling edge -> ACK1; latch sel=best and freeze=1 next cycle.
//          If nothing eligible, sel=7 and spurious=1.
//   ACK1 : exactly one cycle.
//          Non-spurious: clear_interrupt_request=1<<sel this cycle; ISR[sel] is set at the edge.
//          Spurious: no clear and no ISR change. Then -> WAIT2 and clear the timer.
//   WAIT2: timer+1 each cycle.
//          Second INTA falling edge -> ACK2; a first rise is required before it.
//          timer==ACK_TIMEOUT-1 -> ack_error pulse, ISR[sel] cleared (not if spurious), freeze=0, -> IDLE.
//   ACK2 : vector_valid=1 and vector_out={vector_base,sel} while inta_n low.
//          On inta_n rising: if auto_eoi and not spurious, clear ISR[sel] (rotate if priority_rotate).
//          In all cases freeze=0 and vector_valid=0 next cycle, -> IDLE.
//  freeze is registered: high from the cycle after the first falling edge until the cycle after ACK2/abort exit.
//  EOI is honoured in every state; eoi_nonspecific and eoi_specific together -> specific wins.
//   A non-specific EOI with ISR=0 is a no-op.
//   With priority_rotate, lowest_prio takes the cleared level.
//  ISR set (ACK1) and EOI clear of the same bit in the same cycle -> set wins.
//  An async reset mid-handshake aborts immediately: no ack_error and no vector is driven.
// TESTING
//  1. IRR=0x08, IMR=0: INT=1; INTA low 2 cyc, high 3, low 2 ->
//     clear=0x08 one cycle, ISR=0x08, INT=0, vector_out={base,3'd3}.
//  2. ISR=0x02 (IR1 in service), IRR=0x01: INT=1 (IR0 outranks).
//     With IRR=0x04 instead: INT=0 until a non-specific EOI, then ISR=0 and INT=1.
//  3. auto_eoi=1, priority_rotate=1, IRR=0x01: after ACK2 rise, ISR=0 and lowest_prio=0.
//     Then IRR=0x81 -> best=IR1? No: best=7. IR1..IR7 rank above IR0, so IR7 is taken.
//  4. First INTA, then no second pulse for ACK_TIMEOUT cycles -> ack_error pulse, ISR bit cleared, freeze=0, state IDLE.
//  5. IRR withdrawn before first INTA (eligible=0) -> spurious.
//     vector={base,3'd7}, ISR unchanged, no clear pulse.
//  6. reset_n low during WAIT2 -> all outputs 0 asynchronously.
//     After reset_n release with IRR=0x10, a new handshake completes normally.

Source files
------------

// File: rtl/interrupt_acknowledge_sequencer.sv
// 8259-style interrupt acknowledge sequencer: priority resolution against the ISR,
// two-pulse INTA handshake, IRR freeze/clear, EOI/AEOI handling and vector generation.
module interrupt_acknowledge_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       icw1_reset,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       priority_rotate,
  input  logic       eoi_nonspecific,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       inta_n,
  output logic       interrupt,
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  output logic       ack_error
);

  localparam int unsigned TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic            spur_q, spur_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      isr_q, isr_d;
  logic [2:0]      lowest_q, lowest_d;
  logic            freeze_q, freeze_d;
  logic            ack_error_q, ack_error_d;
  logic            inta_n_q;

  logic [3:0]      best;
  logic [3:0]      isr_top;
  logic            inta_fall;
  logic            inta_rise;

  // Returns {found, level} of the highest-priority set bit; lowest+1 ranks first.
  function automatic logic [3:0] pick_highest(input logic [7:0] req, input logic [2:0] lowest);
    logic [3:0] res;
    logic [2:0] lvl;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      lvl = lowest + 3'(k) + 3'd1;
      if (req[lvl]) res = {1'b1, lvl};
    end
    return res;
  endfunction

  function automatic logic [2:0] rank_of(input logic [2:0] lvl, input logic [2:0] lowest);
    return lvl - lowest - 3'd1;
  endfunction

  assign best      = pick_highest(interrupt_request_register & ~interrupt_mask, lowest_q);
  assign isr_top   = pick_highest(isr_q, lowest_q);
  assign inta_fall = inta_n_q & ~inta_n;
  assign inta_rise = ~inta_n_q & inta_n;

  assign interrupt = reset_n && (state_q == IDLE) && best[3] &&
                     (!isr_top[3] || (rank_of(best[2:0], lowest_q) < rank_of(isr_top[2:0], lowest_q)));

  assign freeze                  = freeze_q;
  assign ack_error               = ack_error_q;
  assign in_service_register     = isr_q;
  assign vector_valid            = (state_q == ACK2);
  assign vector_out              = (state_q == ACK2) ? {vector_base, sel_q} : 8'h00;
  assign clear_interrupt_request = ((state_q == ACK1) && !spur_q) ? (8'h01 << sel_q) : 8'h00;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      spur_q      <= 1'b0;
      timer_q     <= '0;
      isr_q       <= 8'h00;
      lowest_q    <= 3'd7;
      freeze_q    <= 1'b0;
      ack_error_q <= 1'b0;
      inta_n_q    <= 1'b1;
    end else if (icw1_reset) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      spur_q      <= 1'b0;
      timer_q     <= '0;
      isr_q       <= 8'h00;
      lowest_q    <= 3'd7;
      freeze_q    <= 1'b0;
      ack_error_q <= 1'b0;
      inta_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      spur_q      <= spur_d;
      timer_q     <= timer_d;
      isr_q       <= isr_d;
      lowest_q    <= lowest_d;
      freeze_q    <= freeze_d;
      ack_error_q <= ack_error_d;
      inta_n_q    <= inta_n;
    end
  end

  // EOI clears first so that an ACK1 set of the same bit takes precedence.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    spur_d      = spur_q;
    timer_d     = timer_q;
    isr_d       = isr_q;
    lowest_d    = lowest_q;
    ack_error_d = 1'b0;

    if (eoi_specific) begin
      isr_d[eoi_level] = 1'b0;
      if (priority_rotate) lowest_d = eoi_level;
    end else if (eoi_nonspecific && isr_top[3]) begin
      isr_d[isr_top[2:0]] = 1'b0;
      if (priority_rotate) lowest_d = isr_top[2:0];
    end

    case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d = ACK1;
          sel_d   = best[3] ? best[2:0] : 3'd7;
          spur_d  = ~best[3];
        end
      end
      ACK1: begin
        if (!spur_q) isr_d[sel_q] = 1'b1;
        timer_d = '0;
        state_d = WAIT2;
      end
      WAIT2: begin
        timer_d = timer_q + TW'(1);
        if (inta_fall) begin
          state_d = ACK2;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          ack_error_d = 1'b1;
          if (!spur_q) isr_d[sel_q] = 1'b0;
          state_d = IDLE;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          if (auto_eoi && !spur_q) begin
            isr_d[sel_q] = 1'b0;
            if (priority_rotate) lowest_d = sel_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    freeze_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Self-checking bench: directed handshake scenarios plus randomized handshakes/EOIs
// compared against a rank-arithmetic model of the ISR and rotating priority.
module tb_interrupt_acknowledge_sequencer;

  localparam int unsigned TO = 20;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       icw1_reset;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [4:0] base;
  logic       aeoi;
  logic       rot;
  logic       eoi_ns;
  logic       eoi_sp;
  logic [2:0] eoi_lvl;
  logic       inta_n;
  logic       interrupt;
  logic       freeze;
  logic [7:0] clear_irq;
  logic [7:0] isr;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic       ack_error;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] isr_m;
  int         lowest_m;

  always #5 clock = ~clock;

  interrupt_acknowledge_sequencer #(.ACK_TIMEOUT(TO)) dut (
    .clock                      (clock),
    .reset_n                    (reset_n),
    .icw1_reset                 (icw1_reset),
    .interrupt_request_register (irr),
    .interrupt_mask             (imr),
    .vector_base                (base),
    .auto_eoi                   (aeoi),
    .priority_rotate            (rot),
    .eoi_nonspecific            (eoi_ns),
    .eoi_specific               (eoi_sp),
    .eoi_level                  (eoi_lvl),
    .inta_n                     (inta_n),
    .interrupt                  (interrupt),
    .freeze                     (freeze),
    .clear_interrupt_request    (clear_irq),
    .in_service_register        (isr),
    .vector_out                 (vector_out),
    .vector_valid               (vector_valid),
    .ack_error                  (ack_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic int rank_m(input int lvl);
    return (lvl - lowest_m + 7) % 8;
  endfunction

  function automatic int best_m(input logic [7:0] req);
    int b;
    b = -1;
    for (int i = 0; i < 8; i++)
      if (req[i] && (b < 0 || rank_m(i) < rank_m(b))) b = i;
    return b;
  endfunction

  function automatic logic exp_int();
    int b;
    int t;
    b = best_m(irr & ~imr);
    t = best_m(isr_m);
    return (b >= 0) && (t < 0 || rank_m(b) < rank_m(t));
  endfunction

  task automatic model_reset();
    isr_m    = 8'h00;
    lowest_m = 7;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_int"}, 32'(interrupt), 0);
    check_eq({tag, "_frz"}, 32'(freeze), 0);
    check_eq({tag, "_clr"}, 32'(clear_irq), 0);
    check_eq({tag, "_isr"}, 32'(isr), 0);
    check_eq({tag, "_vec"}, 32'(vector_out), 0);
    check_eq({tag, "_vv"}, 32'(vector_valid), 0);
    check_eq({tag, "_err"}, 32'(ack_error), 0);
  endtask

  // Full two-pulse handshake (or first pulse then abort) with model updates.
  task automatic handshake(input bit timeout);
    int  b;
    int  sel;
    bit  spur;
    #1;
    b    = best_m(irr & ~imr);
    spur = (b < 0);
    sel  = spur ? 7 : b;
    check_eq("int_pre", 32'(interrupt), 32'(exp_int()));
    inta_n = 1'b0;
    tick();
    check_eq("frz_ack1", 32'(freeze), 1);
    check_eq("clr_ack1", 32'(clear_irq), spur ? 32'd0 : (32'd1 << sel));
    if (!spur) irr = irr & ~(8'h01 << sel);
    tick();
    if (!spur) isr_m[sel] = 1'b1;
    check_eq("isr_set", 32'(isr), 32'(isr_m));
    check_eq("clr_off", 32'(clear_irq), 0);
    check_eq("int_busy", 32'(interrupt), 0);
    inta_n = 1'b1;
    if (timeout) begin
      repeat (TO - 1) tick();
      check_eq("frz_wait", 32'(freeze), 1);
      check_eq("err_early", 32'(ack_error), 0);
      tick();
      if (!spur) isr_m[sel] = 1'b0;
      check_eq("err_pulse", 32'(ack_error), 1);
      check_eq("frz_abort", 32'(freeze), 0);
      check_eq("isr_abort", 32'(isr), 32'(isr_m));
      check_eq("vv_abort", 32'(vector_valid), 0);
      tick();
      check_eq("err_off", 32'(ack_error), 0);
      return;
    end
    repeat (3) tick();
    inta_n = 1'b0;
    tick();
    check_eq("vv_ack2", 32'(vector_valid), 1);
    check_eq("vec_ack2", 32'(vector_out), 32'({base, 3'(sel)}));
    check_eq("frz_ack2", 32'(freeze), 1);
    tick();
    inta_n = 1'b1;
    tick();
    if (aeoi && !spur) begin
      isr_m[sel] = 1'b0;
      if (rot) lowest_m = sel;
    end
    check_eq("vv_done", 32'(vector_valid), 0);
    check_eq("frz_done", 32'(freeze), 0);
    check_eq("isr_done", 32'(isr), 32'(isr_m));
    check_eq("vec_done", 32'(vector_out), 0);
    check_eq("err_none", 32'(ack_error), 0);
  endtask

  task automatic issue_eoi(input bit ns, input bit sp, input logic [2:0] lv);
    int t;
    eoi_ns  = ns;
    eoi_sp  = sp;
    eoi_lvl = lv;
    tick();
    eoi_ns = 1'b0;
    eoi_sp = 1'b0;
    if (sp) begin
      isr_m[lv] = 1'b0;
      if (rot) lowest_m = int'(lv);
    end else if (ns) begin
      t = best_m(isr_m);
      if (t >= 0) begin
        isr_m[t] = 1'b0;
        if (rot) lowest_m = t;
      end
    end
    #1;
    check_eq("isr_eoi", 32'(isr), 32'(isr_m));
    check_eq("int_eoi", 32'(interrupt), 32'(exp_int()));
  endtask

  initial begin
    reset_n    = 1'b0;
    icw1_reset = 1'b0;
    irr        = 8'h00;
    imr        = 8'h00;
    base       = 5'h15;
    aeoi       = 1'b0;
    rot        = 1'b0;
    eoi_ns     = 1'b0;
    eoi_sp     = 1'b0;
    eoi_lvl    = 3'd0;
    inta_n     = 1'b1;
    model_reset();
    #12;
    check_all_zero("rst");
    reset_n = 1'b1;
    tick();

    // Single request on IR3, no AEOI.
    irr = 8'h08;
    #1;
    check_eq("t1_int", 32'(interrupt), 1);
    handshake(0);
    check_eq("t1_isr", 32'(isr), 32'h08);
    check_eq("t1_int_after", 32'(interrupt), 0);

    // ICW1 re-init clears the ISR.
    icw1_reset = 1'b1;
    tick();
    icw1_reset = 1'b0;
    model_reset();
    check_eq("icw1_isr", 32'(isr), 0);

    // Fully nested: IR1 in service.
    irr = 8'h02;
    handshake(0);
    irr = 8'h01;
    #1;
    check_eq("t2_int_ir0", 32'(interrupt), 1);
    irr = 8'h04;
    #1;
    check_eq("t2_int_ir2", 32'(interrupt), 0);
    issue_eoi(1'b1, 1'b0, 3'd0);
    check_eq("t2_int_after", 32'(interrupt), 1);

    // AEOI with rotation: IR0 becomes lowest, so IR7 wins next.
    aeoi = 1'b1;
    rot  = 1'b1;
    irr  = 8'h01;
    handshake(0);
    irr = 8'h81;
    #1;
    check_eq("t3_best", 32'(best_m(irr & ~imr)), 7);
    handshake(0);
    aeoi = 1'b0;
    rot  = 1'b0;

    // Timeout abort.
    irr = 8'h20;
    handshake(1);

    // Spurious: nothing eligible at the first INTA.
    irr = 8'h00;
    handshake(0);

    // Async reset during WAIT2.
    irr    = 8'h10;
    inta_n = 1'b0;
    tick();
    tick();
    inta_n = 1'b1;
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("arst");
    tick();
    reset_n = 1'b1;
    tick();
    irr = 8'h10;
    handshake(0);

    // Randomized handshakes and EOIs.
    for (int n = 0; n < 40; n++) begin
      irr  = 8'($urandom);
      imr  = 8'($urandom) & 8'($urandom);
      aeoi = 1'($urandom);
      rot  = 1'($urandom);
      base = 5'($urandom);
      handshake(($urandom % 8) == 0);
      case ($urandom % 4)
        1: issue_eoi(1'b1, 1'b0, 3'd0);
        2: issue_eoi(1'($urandom), 1'b1, 3'($urandom));
        3: issue_eoi(1'b1, 1'b0, 3'd0);
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
